// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Index width that stays legal (>=1 bit) even for a single requester.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO write-port bundle for fifo_wr_arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  import fifo_arb_pkg::*;

  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_full;
  logic                          grant_valid;
  logic [ID_W-1:0]               grant_id;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
  );

  // Requesters / FIFO side.
  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first requester with valid set, scanning upward from
// the one after i_last_id and wrapping, so the last owner is checked last.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_id,
  output logic [ID_W-1:0]    o_pick,
  output logic               o_any
);

  function automatic logic [ID_W-1:0] wrap_id(input int v);
    return ID_W'(v % NUM_REQ);
  endfunction

  // Scan farthest-first so the nearest valid index after i_last_id wins.
  always_comb begin
    o_pick = i_last_id;
    o_any  = |i_req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (i_req[wrap_id(int'(i_last_id) + k)]) begin
        o_pick = wrap_id(int'(i_last_id) + k);
      end else begin
        o_pick = o_pick;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between NUM_REQ valid/ready requesters.
// Round-robin grant, at most BURST_MAX beats per grant, one idle bubble
// between grants. A full FIFO freezes the current grant until space frees.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.master  arb_if
);

  localparam int ID_W = id_w(NUM_REQ);
  localparam int BC_W = $clog2(BURST_MAX + 1);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [ID_W-1:0]       r_grant_id;
  logic [ID_W-1:0]       r_last_id;
  logic [BC_W-1:0]       r_beat_cnt;
  logic [BC_W-1:0]       w_beat_nxt;
  logic [ID_W-1:0]       w_pick;
  logic                  w_any;
  logic                  w_sel_valid;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_wr_en;
  logic                  w_last_beat;
  logic                  w_release;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req     (arb_if.req_valid),
    .i_last_id (r_last_id),
    .o_pick    (w_pick),
    .o_any     (w_any)
  );

  assign w_sel_valid = arb_if.req_valid[r_grant_id];
  assign w_sel_data  = arb_if.req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign w_wr_en     = (r_state == ARB_GRANT) && w_sel_valid && !arb_if.fifo_full;
  assign w_beat_nxt  = r_beat_cnt + BC_W'(1);
  assign w_last_beat = (w_beat_nxt == BC_W'(BURST_MAX));
  // Burst exhausted, or the owner withdrew; a full stall with valid held is neither.
  assign w_release   = (w_wr_en && w_last_beat) || !w_sel_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: grant whenever anyone asks, drop back to IDLE on release.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:  w_state_nxt = w_any ? ARB_GRANT : ARB_IDLE;
      ARB_GRANT: w_state_nxt = w_release ? ARB_IDLE : ARB_GRANT;
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  // Grant owner, round-robin pointer and burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_id <= {ID_W{1'b0}};
      r_last_id  <= ID_W'(NUM_REQ - 1);
      r_beat_cnt <= {BC_W{1'b0}};
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_grant_id <= w_pick;
            r_beat_cnt <= {BC_W{1'b0}};
          end
        end
        ARB_GRANT: begin
          if (w_release) begin
            r_last_id  <= r_grant_id;
            r_beat_cnt <= {BC_W{1'b0}};
          end else if (w_wr_en) begin
            r_beat_cnt <= w_beat_nxt;
          end
        end
        default: begin
          r_beat_cnt <= {BC_W{1'b0}};
        end
      endcase
    end
  end

  // Outputs: only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    arb_if.req_ready    = {NUM_REQ{1'b0}};
    arb_if.fifo_wr_en   = 1'b0;
    arb_if.fifo_wr_data = {DATA_WIDTH{1'b0}};
    arb_if.grant_valid  = 1'b0;
    case (r_state)
      ARB_GRANT: begin
        if (arb_if.fifo_full) begin
          arb_if.req_ready = {NUM_REQ{1'b0}};
        end else begin
          arb_if.req_ready = NUM_REQ'(1) << r_grant_id;
        end
        arb_if.fifo_wr_en   = w_wr_en;
        arb_if.fifo_wr_data = w_sel_data;
        arb_if.grant_valid  = 1'b1;
      end
      default: begin
        arb_if.grant_valid = 1'b0;
      end
    endcase
  end

  assign arb_if.grant_id = r_grant_id;

endmodule
